mmio_uart_bridge: RTL and testbench

Memory-mapped I/O bridge between the CPU memory stage and the on-chip UART, decoding the 0x8000_0000 I/O region. It adds RX and TX byte FIFOs so software does not drop bytes between polls. It also holds the cycle and retired-instruction counters used for benchmarking. Read data is registered, giving the same one-cycle latency as the BIOS, DMEM and IMEM paths.

---
 rtl/mmio_pkg.sv | 42 ++++
 rtl/mmio_uart_bridge_if.sv | 18 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mmio_uart_bridge.sv | 128 ++++++++++++
 tb/tb_mmio_uart_bridge.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared register map for the MMIO UART bridge: offsets, status bit
// positions and the offset decoder used by the bridge.
package mmio_pkg;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX_DATA = 8'h04;
    localparam logic [7:0] OFF_TX_DATA = 8'h08;
    localparam logic [7:0] OFF_CYCLE   = 8'h10;
    localparam logic [7:0] OFF_INST    = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR = 8'h18;

    localparam int STAT_TX_NOT_FULL  = 0;
    localparam int STAT_RX_NOT_EMPTY = 1;
    localparam int STAT_RX_COUNT_LSB = 8;
    localparam int STAT_TX_COUNT_LSB = 16;

    typedef enum logic [2:0] {
        REG_STATUS  = 3'd0,
        REG_RX_DATA = 3'd1,
        REG_TX_DATA = 3'd2,
        REG_CYCLE   = 3'd3,
        REG_INST    = 3'd4,
        REG_CNT_CLR = 3'd5,
        REG_NONE    = 3'd6
    } reg_sel_e;

    // Map a byte offset onto the register it addresses; unmapped offsets give REG_NONE.
    function automatic reg_sel_e decode_offset(input logic [7:0] off);
        reg_sel_e sel;
        case (off)
            OFF_STATUS:  sel = REG_STATUS;
            OFF_RX_DATA: sel = REG_RX_DATA;
            OFF_TX_DATA: sel = REG_TX_DATA;
            OFF_CYCLE:   sel = REG_CYCLE;
            OFF_INST:    sel = REG_INST;
            OFF_CNT_CLR: sel = REG_CNT_CLR;
            default:     sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_uart_bridge_if.sv
// CPU memory-stage side of the MMIO bridge: address, data and strobes.
interface mmio_uart_bridge_if;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic        io_re;
    logic        io_we;
    logic [31:0] io_rdata;

    modport master (
        output io_addr, io_wdata, io_re, io_we,
        input  io_rdata
    );

    modport slave (
        input  io_addr, io_wdata, io_re, io_we,
        output io_rdata
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through output. Pushes while full
// and pops while empty are ignored; dout reads zero when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Full is judged on the current count, so a same-cycle pop never frees room for a push.
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign empty     = (count_r == (AW+1)'(0));
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

    // Storage write; contents need no reset because empty masks dout.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= (AW+1)'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/mmio_uart_bridge.sv
// MMIO bridge between the CPU memory stage and the UART: RX/TX byte FIFOs,
// status register and benchmark counters, with one-cycle registered reads.
module mmio_uart_bridge
    import mmio_pkg::*;
#(
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [3:0] IO_BASE_NIBBLE = 4'h8
) (
    input  logic                 clk,
    input  logic                 rst,
    mmio_uart_bridge_if.slave    io,
    input  logic                 inst_retired,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel_s;
    reg_sel_e      reg_s;
    logic          rd_req_s;
    logic          wr_req_s;
    logic          rx_pop_s;
    logic          tx_push_s;
    logic          cnt_clr_s;
    logic [7:0]    rx_dout_s;
    logic          rx_full_s;
    logic          rx_empty_s;
    logic [CW-1:0] rx_count_s;
    logic [7:0]    tx_dout_s;
    logic          tx_full_s;
    logic          tx_empty_s;
    logic [CW-1:0] tx_count_s;
    logic [31:0]   status_s;
    logic [31:0]   rdata_next_s;
    logic [31:0]   rdata_r;
    logic [31:0]   cycle_count_r;
    logic [31:0]   inst_count_r;
    logic          unused_bits_s;

    assign sel_s     = (io.io_addr[31:28] == IO_BASE_NIBBLE);
    assign reg_s     = decode_offset(io.io_addr[7:0]);
    // A combined load+store is treated as a store only.
    assign rd_req_s  = sel_s && io.io_re && !io.io_we;
    assign wr_req_s  = sel_s && io.io_we;
    assign rx_pop_s  = rd_req_s && (reg_s == REG_RX_DATA);
    assign tx_push_s = wr_req_s && (reg_s == REG_TX_DATA);
    assign cnt_clr_s = wr_req_s && (reg_s == REG_CNT_CLR);

    assign unused_bits_s = ^{io.io_addr[27:8], io.io_wdata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_valid && !rx_full_s),
        .din   (rx_data),
        .pop   (rx_pop_s),
        .dout  (rx_dout_s),
        .full  (rx_full_s),
        .empty (rx_empty_s),
        .count (rx_count_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push_s),
        .din   (io.io_wdata[7:0]),
        .pop   (!tx_empty_s && tx_ready),
        .dout  (tx_dout_s),
        .full  (tx_full_s),
        .empty (tx_empty_s),
        .count (tx_count_s)
    );

    assign rx_ready    = !rx_full_s;
    assign tx_valid    = !tx_empty_s;
    assign tx_data     = tx_dout_s;
    assign io.io_rdata = rdata_r;

    // Assemble the status word from current FIFO occupancy.
    always_comb begin
        status_s                                  = 32'h0000_0000;
        status_s[STAT_TX_NOT_FULL]                = !tx_full_s;
        status_s[STAT_RX_NOT_EMPTY]               = !rx_empty_s;
        status_s[STAT_RX_COUNT_LSB +: CW]         = rx_count_s;
        status_s[STAT_TX_COUNT_LSB +: CW]         = tx_count_s;
    end

    // Select read data from pre-update state; anything but a selected read yields zero.
    always_comb begin
        rdata_next_s = 32'h0000_0000;
        if (rd_req_s) begin
            case (reg_s)
                REG_STATUS:  rdata_next_s = status_s;
                REG_RX_DATA: rdata_next_s = {24'h00_0000, rx_dout_s};
                REG_CYCLE:   rdata_next_s = cycle_count_r;
                REG_INST:    rdata_next_s = inst_count_r;
                default:     rdata_next_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_next_s = 32'h0000_0000;
        end
    end

    // Register the load data for one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r <= 32'h0000_0000;
        end else begin
            rdata_r <= rdata_next_s;
        end
    end

    // Benchmark counters; a clear write overrides any same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr_s) begin
            cycle_count_r <= 32'h0000_0000;
            inst_count_r  <= 32'h0000_0000;
        end else begin
            cycle_count_r <= cycle_count_r + 32'd1;
            inst_count_r  <= inst_count_r + {31'd0, inst_retired};
        end
    end
endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed, table-driven bench for mmio_uart_bridge with hand sequences
// for FIFO full/backpressure, counters, simultaneous ops and mid-op reset.
module tb_mmio_uart_bridge;

    logic       clk;
    logic       rst;
    logic       inst_retired;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int checks;
    int errors;

    mmio_uart_bridge_if bus();

    mmio_uart_bridge #(.FIFO_DEPTH(8), .IO_BASE_NIBBLE(4'h8)) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (bus),
        .inst_retired (inst_retired),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic [31:0] exp_rdata;
        logic        exp_rxr;
        logic        exp_txv;
        logic [7:0]  exp_txd;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic rxv, input logic [7:0] rxd,
                           input logic txr, input logic [31:0] er, input logic erxr,
                           input logic etxv, input logic [7:0] etxd);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rxv = rxv; v.rxd = rxd; v.txr = txr;
        v.exp_rdata = er; v.exp_rxr = erxr; v.exp_txv = etxv; v.exp_txd = etxd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.io_addr  = 32'h0;
        bus.io_wdata = 32'h0;
        bus.io_re    = 1'b0;
        bus.io_we    = 1'b0;
        inst_retired = 1'b0;
        rx_valid     = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr);
        bus.io_addr = addr;
        bus.io_re   = 1'b1;
        bus.io_we   = 1'b0;
        step();
        bus.io_re   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.io_addr  = addr;
        bus.io_wdata = data;
        bus.io_we    = 1'b1;
        bus.io_re    = 1'b0;
        step();
        bus.io_we    = 1'b0;
    endtask

    logic [7:0] tx_exp [8];

    initial begin
        checks = 0;
        errors = 0;
        tx_ready = 1'b0;
        @(negedge clk);
        do_reset();

        chk("reset_rdata", bus.io_rdata, 32'h0);
        chk("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("reset_tx_data", {24'd0, tx_data}, 32'd0);

        // re we addr wdata rxv rxd txr | rdata rxr txv txd
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0001, 1, 0, 8'h00);
        add_vec(0, 0, 32'h0000_0000, 32'h0, 1, 8'h41, 0, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(0, 0, 32'h0000_0000, 32'h0, 1, 8'h42, 0, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0203, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0004, 32'h0, 0, 8'h00, 0, 32'h0000_0041, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0103, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8ABC_DE04, 32'h0, 0, 8'h00, 0, 32'h0000_0042, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0001, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0004, 32'h0, 0, 8'h00, 0, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0001, 1, 0, 8'h00);
        add_vec(1, 0, 32'h0000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_000C, 32'h0, 0, 8'h00, 0, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(0, 1, 32'h8000_0008, 32'h1234_5677, 0, 8'h00, 0, 32'h0000_0000, 1, 1, 8'h77);
        add_vec(1, 1, 32'h8000_0008, 32'h0000_0088, 0, 8'h00, 0, 32'h0000_0000, 1, 1, 8'h77);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0002_0001, 1, 1, 8'h77);
        add_vec(0, 1, 32'h1000_0008, 32'h0000_0099, 0, 8'h00, 0, 32'h0000_0000, 1, 1, 8'h77);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0002_0001, 1, 1, 8'h77);
        add_vec(0, 0, 32'h0000_0000, 32'h0, 0, 8'h00, 1, 32'h0000_0000, 1, 1, 8'h88);
        add_vec(0, 0, 32'h0000_0000, 32'h0, 0, 8'h00, 1, 32'h0000_0000, 1, 0, 8'h00);
        add_vec(1, 0, 32'h8000_0000, 32'h0, 0, 8'h00, 0, 32'h0000_0001, 1, 0, 8'h00);

        foreach (vecs[i]) begin
            bus.io_re    = vecs[i].re;
            bus.io_we    = vecs[i].we;
            bus.io_addr  = vecs[i].addr;
            bus.io_wdata = vecs[i].wdata;
            rx_valid     = vecs[i].rxv;
            rx_data      = vecs[i].rxd;
            tx_ready     = vecs[i].txr;
            step();
            chk($sformatf("vec%0d_rdata", i), bus.io_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_rx_ready", i), {31'd0, rx_ready}, {31'd0, vecs[i].exp_rxr});
            chk($sformatf("vec%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].exp_txv});
            chk($sformatf("vec%0d_tx_data", i), {24'd0, tx_data}, {24'd0, vecs[i].exp_txd});
        end
        idle_inputs();
        tx_ready = 1'b0;

        // RX full: eight bytes fill the FIFO, further bytes are refused.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'h10 + i);
            step();
        end
        rx_valid = 1'b0;
        chk("rxfull_ready", {31'd0, rx_ready}, 32'd0);
        rd(32'h8000_0000);
        chk("rxfull_status", bus.io_rdata, 32'h0000_0803);
        rx_valid = 1'b1;
        rx_data  = 8'h99;
        step();
        step();
        chk("rxfull_hold_ready", {31'd0, rx_ready}, 32'd0);
        rd(32'h8000_0004);
        chk("rxfull_first", bus.io_rdata, 32'h0000_0010);
        chk("rxfull_ready_rise", {31'd0, rx_ready}, 32'd1);
        rx_valid = 1'b0;
        rd(32'h8000_0000);
        chk("rxfull_status7", bus.io_rdata, 32'h0000_0703);
        for (int i = 0; i < 7; i++) begin
            rd(32'h8000_0004);
            chk($sformatf("rxfull_drain%0d", i), bus.io_rdata, 32'(8'h11 + i));
        end
        rd(32'h8000_0004);
        chk("rxfull_no_99", bus.io_rdata, 32'h0);

        // TX backpressure: ten stores into an eight-deep FIFO.
        do_reset();
        tx_ready = 1'b0;
        wr(32'h8000_0008, 32'h0000_0055);
        for (int i = 0; i < 9; i++) begin
            wr(32'h8000_0008, 32'(8'h60 + i));
        end
        rd(32'h8000_0000);
        chk("txbp_status", bus.io_rdata, 32'h0008_0000);
        tx_exp[0] = 8'h55;
        for (int i = 1; i < 8; i++) begin
            tx_exp[i] = 8'(8'h60 + i - 1);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("txbp_valid%0d", i), {31'd0, tx_valid}, 32'd1);
            chk($sformatf("txbp_data%0d", i), {24'd0, tx_data}, {24'd0, tx_exp[i]});
            step();
        end
        chk("txbp_drained", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Counters: 20 cycles with 5 retirements, then clear with a coincident pulse.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            inst_retired = (i % 4 == 0);
            step();
        end
        inst_retired = 1'b0;
        rd(32'h8000_0014);
        chk("cnt_inst5", bus.io_rdata, 32'd5);
        rd(32'h8000_0010);
        chk("cnt_cycle21", bus.io_rdata, 32'd21);
        inst_retired = 1'b1;
        wr(32'h8000_0018, 32'hFFFF_FFFF);
        inst_retired = 1'b0;
        rd(32'h8000_0010);
        chk("cnt_clr_cycle", bus.io_rdata, 32'd0);
        rd(32'h8000_0014);
        chk("cnt_clr_inst", bus.io_rdata, 32'd0);

        force dut.cycle_count_r = 32'hFFFF_FFFF;
        rd(32'h8000_0010);
        chk("cnt_forced", bus.io_rdata, 32'hFFFF_FFFF);
        release dut.cycle_count_r;
        step();
        rd(32'h8000_0010);
        checks++;
        if (bus.io_rdata > 32'd3) begin
            errors++;
            $display("FAIL cnt_wrap: got 0x%08h expected a value below 0x00000004", bus.io_rdata);
        end

        // Simultaneous RX push and pop at count 3.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'hA1 + i);
            step();
        end
        rx_data = 8'hA4;
        rd(32'h8000_0004);
        rx_valid = 1'b0;
        chk("simul_pop", bus.io_rdata, 32'h0000_00A1);
        rd(32'h8000_0000);
        chk("simul_status", bus.io_rdata, 32'h0000_0303);
        for (int i = 0; i < 3; i++) begin
            rd(32'h8000_0004);
            chk($sformatf("simul_order%0d", i), bus.io_rdata, 32'(8'hA2 + i));
        end

        // Reset with both FIFOs half full and a read pending.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(8'hB0 + i);
            step();
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(32'h8000_0008, 32'(8'hC0 + i));
        end
        rd(32'h8000_0000);
        chk("midrst_pre_status", bus.io_rdata, 32'h0004_0403);
        bus.io_addr = 32'h8000_0004;
        bus.io_re   = 1'b1;
        rst         = 1'b1;
        step();
        chk("midrst_rdata", bus.io_rdata, 32'h0);
        chk("midrst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_tx_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        bus.io_re = 1'b0;
        rd(32'h8000_0000);
        chk("midrst_status", bus.io_rdata, 32'h0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
